// File: rtl/dot_prod_lanes_if.sv
// dot_prod_lanes_if: frame start, valid/ready beat and result bundle
// for the multi-lane dot-product engine.
interface dot_prod_lanes_if #(
  parameter int XLEN_PIXEL = 8,
  parameter int LANES      = 4,
  parameter int ACC_W      = 32
);
  logic                        start;
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*XLEN_PIXEL-1:0] x_test;
  logic [LANES*XLEN_PIXEL-1:0] x_sv;
  logic                        busy;
  logic [ACC_W-1:0]            mac_out;
  logic                        out_valid;
  logic                        overflow;

  modport master (
    output start,
    output in_valid,
    output x_test,
    output x_sv,
    input  in_ready,
    input  busy,
    input  mac_out,
    input  out_valid,
    input  overflow
  );

  modport slave (
    input  start,
    input  in_valid,
    input  x_test,
    input  x_sv,
    output in_ready,
    output busy,
    output mac_out,
    output out_valid,
    output overflow
  );
endinterface

// File: rtl/dot_prod_lanes.sv
// dot_prod_lanes: LANES-wide unsigned dot product over NUM_OF_PIXELS.
// Define DOT_PROD_SATURATE_EN to clamp the accumulator on overflow.
module dot_prod_lanes #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 900,
  parameter int LANES         = 4,
  parameter int ACC_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  dot_prod_lanes_if.slave    bus
);
  localparam int BEATS  =
    (NUM_OF_PIXELS + LANES - 1) / LANES;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int PROD_W = 2 * XLEN_PIXEL;
  localparam int TREE_W =
    PROD_W + $clog2(LANES + 1);
  localparam int WIDE_W =
    (ACC_W > TREE_W) ? ACC_W : TREE_W;
  localparam int SUM_W  = WIDE_W + 1;
  // lanes carrying real pixels on the final beat
  localparam int LAST_VALID =
    NUM_OF_PIXELS - (BEATS - 1) * LANES;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_e;

  state_e                         state_q;
  state_e                         state_d;
  logic [CNT_W-1:0]               cnt_q;
  logic [LANES-1:0][PROD_W-1:0]   prod_q;
  logic [LANES-1:0][PROD_W-1:0]   prod_d;
  logic                           s1_vld_q;
  logic [ACC_W-1:0]               acc_q;
  logic [ACC_W-1:0]               acc_d;
  logic                           ov_q;
  logic [ACC_W-1:0]               mac_q;
  logic                           outv_q;

  logic                           in_ready;
  logic                           clr;
  logic                           accept;
  logic                           last_beat;
  logic [TREE_W-1:0]              tree;
  logic [SUM_W-1:0]               sum;
  logic                           carry;

  assign last_beat =
    (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    clr      = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        accept   = bus.in_valid;
        if (accept && last_beat)
          state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod_d = '0;
    for (int l = 0; l < LANES; l++) begin
      prod_d[l] =
        PROD_W'(bus.x_test[l*XLEN_PIXEL +: XLEN_PIXEL])
        * PROD_W'(bus.x_sv[l*XLEN_PIXEL +: XLEN_PIXEL]);
      if (last_beat && (l >= LAST_VALID))
        prod_d[l] = '0;
    end
  end

  always_comb begin
    tree = '0;
    for (int l = 0; l < LANES; l++)
      tree = tree + TREE_W'(prod_q[l]);
  end

  // carry is anything that lands above the ACC_W bits
  assign sum   = SUM_W'(acc_q) + SUM_W'(tree);
  assign carry = |sum[SUM_W-1:ACC_W];

  always_comb begin
`ifdef DOT_PROD_SATURATE_EN
    if (carry || ov_q)
      acc_d = '1;
    else
      acc_d = sum[ACC_W-1:0];
`else
    acc_d = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      s1_vld_q <= 1'b0;
      acc_q    <= '0;
      ov_q     <= 1'b0;
      mac_q    <= '0;
      outv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        cnt_q    <= '0;
        acc_q    <= '0;
        ov_q     <= 1'b0;
        s1_vld_q <= 1'b0;
      end else begin
        if (accept) begin
          cnt_q  <= cnt_q + CNT_W'(1);
          prod_q <= prod_d;
        end
        s1_vld_q <= accept;
        if (s1_vld_q) begin
          acc_q <= acc_d;
          ov_q  <= ov_q | carry;
        end
      end
      outv_q <= (state_q == DONE);
      if (state_q == DONE)
        mac_q <= acc_q;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mac_out   = mac_q;
  assign bus.out_valid = outv_q;
  assign bus.overflow  = ov_q;
endmodule

// File: tb/tb_dot_prod_lanes.sv
// tb_dot_prod_lanes: directed vector table plus reset/handshake
// sequences over four differently-sized engine instances.
module tb_dot_prod_lanes;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] xt = '0;
  logic [31:0] xs = '0;

  logic        rdy;
  logic        bsy;
  logic [31:0] mac;
  logic        ovld;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  dot_prod_lanes_if #(.ACC_W(32)) if0 ();
  dot_prod_lanes_if #(.ACC_W(32)) if1 ();
  dot_prod_lanes_if #(.ACC_W(16)) if2 ();
  dot_prod_lanes_if #(.ACC_W(32)) if3 ();

  dot_prod_lanes #(.NUM_OF_PIXELS(8))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  dot_prod_lanes #(.NUM_OF_PIXELS(6))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  dot_prod_lanes #(.NUM_OF_PIXELS(4), .ACC_W(16))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  dot_prod_lanes
    u3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.start = start && (sel == 0);
  assign if1.start = start && (sel == 1);
  assign if2.start = start && (sel == 2);
  assign if3.start = start && (sel == 3);
  assign if0.in_valid = in_valid;
  assign if1.in_valid = in_valid;
  assign if2.in_valid = in_valid;
  assign if3.in_valid = in_valid;
  assign if0.x_test = xt;
  assign if1.x_test = xt;
  assign if2.x_test = xt;
  assign if3.x_test = xt;
  assign if0.x_sv = xs;
  assign if1.x_sv = xs;
  assign if2.x_sv = xs;
  assign if3.x_sv = xs;

  always_comb begin
    rdy = if0.in_ready;
    bsy = if0.busy;
    mac = if0.mac_out;
    ovld = if0.out_valid;
    ovf = if0.overflow;
    case (sel)
      1: begin
        rdy = if1.in_ready;
        bsy = if1.busy;
        mac = if1.mac_out;
        ovld = if1.out_valid;
        ovf = if1.overflow;
      end
      2: begin
        rdy = if2.in_ready;
        bsy = if2.busy;
        mac = 32'(if2.mac_out);
        ovld = if2.out_valid;
        ovf = if2.overflow;
      end
      3: begin
        rdy = if3.in_ready;
        bsy = if3.busy;
        mac = if3.mac_out;
        ovld = if3.out_valid;
        ovf = if3.overflow;
      end
      default: ;
    endcase
  end

  typedef struct {
    int          sel;
    int          nbeats;
    int          gap;
    int          mid;
    logic [31:0] xt_a;
    logic [31:0] xs_a;
    logic [31:0] xt_z;
    logic [31:0] xs_z;
    logic [31:0] exp_mac;
    logic        exp_ov;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v,
                           input string nm);
    bit got;
    int lat;
    sel = v.sel;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < v.nbeats; b++) begin
      if (b > 0) begin
        in_valid = 1'b0;
        repeat (v.gap) begin
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      xt = (b == v.nbeats - 1) ? v.xt_z : v.xt_a;
      xs = (b == v.nbeats - 1) ? v.xs_z : v.xs_a;
      start = (b == v.mid);
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge clk);
        got = rdy;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (!got) begin
        chk({nm, "_accept_timeout"}, 32'(got), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ovld && lat < 10);
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    chk({nm, "_mac"}, mac, v.exp_mac);
    chk({nm, "_ovf"}, 32'(ovf), 32'(v.exp_ov));
    chk({nm, "_busy_at_done"}, 32'(bsy), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_pulse_end"}, 32'(ovld), 32'd0);
    chk({nm, "_mac_hold"}, mac, v.exp_mac);
  endtask

  initial begin
    vecs[0] = '{0, 2, 0, -1,
      32'h03030303, 32'h01010101,
      32'h03030303, 32'h01010101, 32'd24, 1'b0};
    vecs[1] = '{0, 2, 3, -1,
      32'h03030303, 32'h01010101,
      32'h03030303, 32'h01010101, 32'd24, 1'b0};
    vecs[2] = '{1, 2, 0, -1,
      32'h02020202, 32'h02020202,
      32'hFFFF0202, 32'hFFFF0202, 32'd24, 1'b0};
`ifdef DOT_PROD_SATURATE_EN
    vecs[3] = '{2, 1, 0, -1,
      32'hFFFFFFFF, 32'hFFFFFFFF,
      32'hFFFFFFFF, 32'hFFFFFFFF, 32'd65535, 1'b1};
`else
    vecs[3] = '{2, 1, 0, -1,
      32'hFFFFFFFF, 32'hFFFFFFFF,
      32'hFFFFFFFF, 32'hFFFFFFFF, 32'd63492, 1'b1};
`endif
    vecs[4] = '{3, 225, 0, 100,
      32'h01010101, 32'h01010101,
      32'h01010101, 32'h01010101, 32'd900, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk("rst_ready", 32'(rdy), 32'd0);
      chk("rst_busy", 32'(bsy), 32'd0);
      chk("rst_mac", mac, 32'd0);
      chk("rst_ovld", 32'(ovld), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
    end

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i], $sformatf("vec%0d", i));

    // abort a frame with reset one cycle after its first beat
    sel = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", 32'(bsy), 32'd1);
    chk("start_ready", 32'(rdy), 32'd1);
    in_valid = 1'b1;
    xt = 32'h03030303;
    xs = 32'h01010101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", 32'(rdy), 32'd0);
    chk("abort_busy", 32'(bsy), 32'd0);
    chk("abort_mac", mac, 32'd0);
    chk("abort_ovld", 32'(ovld), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    run_frame(vecs[0], "after_rst");

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
